// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetcher: opcodes, cmd_flags bit
// positions, fetch FSM state encoding and instruction length.
package cpu_pkg;

  localparam int INSTR_WORDS = 3;
  localparam int CMD_FLAGS_W = 6;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MOV = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_CMP = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_JE  = 8'h05;
  localparam logic [7:0] OP_JA  = 8'h06;
  localparam logic [7:0] OP_HLT = 8'hFF;

  localparam int FLAG_MOV = 5;
  localparam int FLAG_ADD = 4;
  localparam int FLAG_CMP = 3;
  localparam int FLAG_JMP = 2;
  localparam int FLAG_JE  = 1;
  localparam int FLAG_JA  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_F3,
    S_EXEC,
    S_HALT,
    S_ERROR
  } fetch_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: one-hot executor command flags plus the
// opcodes the fetcher handles itself (NOP, HLT) and the illegal indication.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0]             opcode,
  output logic [CMD_FLAGS_W-1:0] cmd_flags,
  output logic                   is_nop,
  output logic                   is_hlt,
  output logic                   illegal
);

  always_comb begin
    cmd_flags = '0;
    is_nop    = 1'b0;
    is_hlt    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_NOP:  is_nop = 1'b1;
      OP_MOV:  cmd_flags[FLAG_MOV] = 1'b1;
      OP_ADD:  cmd_flags[FLAG_ADD] = 1'b1;
      OP_CMP:  cmd_flags[FLAG_CMP] = 1'b1;
      OP_JMP:  cmd_flags[FLAG_JMP] = 1'b1;
      OP_JE:   cmd_flags[FLAG_JE]  = 1'b1;
      OP_JA:   cmd_flags[FLAG_JA]  = 1'b1;
      OP_HLT:  is_hlt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction sequencer between instruction ROM and executor: fetches 3-word
// instructions, hands commands to the executor and owns PC/halt/error.
// Optional executor watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// F0     | read word0 at pc
// F1     | read word1 at pc+1, capture word0
// F2     | read word2 at pc+2, capture word1
// F3     | capture word2, decode, dispatch or retire NOP/HLT
// EXEC   | command presented to executor, waiting for ready_flag
// HALT   | HLT retired, terminal until rst
// ERROR  | illegal opcode or executor timeout, terminal until rst
module instr_fetcher
  import cpu_pkg::*;
#(
  parameter int                      address_size   = 32,
  parameter int                      word_size      = 32,
  parameter logic [address_size-1:0] START_ADDR     = '0,
  parameter int                      TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rom_rd,
  output logic [address_size-1:0]  rom_addr,
  input  logic [word_size-1:0]     rom_data,
  output logic                     exe_flag,
  output logic [CMD_FLAGS_W-1:0]   cmd_flags,
  output logic [3*word_size-1:0]   cmd_args,
  input  logic                     ready_flag,
  input  logic                     jmp_flag,
  input  logic [address_size-1:0]  new_exe_addr_offset,
  output logic [address_size-1:0]  pc,
  output logic                     halted,
  output logic                     error,
  output logic [31:0]              instr_count
);

  localparam logic [address_size-1:0] ONE  = address_size'(1);
  localparam logic [address_size-1:0] TWO  = address_size'(2);
  localparam logic [address_size-1:0] STEP = address_size'(INSTR_WORDS);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_t                 state_q, state_d;
  logic [address_size-1:0]      pc_q, pc_d;
  logic [word_size-1:0]         w0_q, w0_d, w1_q, w1_d;
  logic                         exe_q, exe_d;
  logic [CMD_FLAGS_W-1:0]       flags_q, flags_d;
  logic [3*word_size-1:0]       args_q, args_d;
  logic                         halted_q, halted_d;
  logic                         error_q, error_d;
  logic [31:0]                  count_q, count_d, count_inc;

  logic [CMD_FLAGS_W-1:0]       dec_flags;
  logic                         dec_nop, dec_hlt, dec_illegal;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  instr_decoder u_dec (
    .opcode    (w0_q[7:0]),
    .cmd_flags (dec_flags),
    .is_nop    (dec_nop),
    .is_hlt    (dec_hlt),
    .illegal   (dec_illegal)
  );

  assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    exe_d    = exe_q;
    flags_d  = flags_q;
    args_d   = args_q;
    halted_d = halted_q;
    error_d  = error_q;
    count_d  = count_q;
    rom_rd   = 1'b0;
    rom_addr = pc_q;
`ifdef FETCH_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_ADDR;
          state_d = S_F0;
        end
      end
      S_F0: begin
        rom_rd  = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        rom_rd   = 1'b1;
        rom_addr = pc_q + ONE;
        w0_d     = rom_data;
        state_d  = S_F2;
      end
      S_F2: begin
        rom_rd   = 1'b1;
        rom_addr = pc_q + TWO;
        w1_d     = rom_data;
        state_d  = S_F3;
      end
      S_F3: begin
        if (dec_illegal) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (dec_hlt) begin
          halted_d = 1'b1;
          count_d  = count_inc;
          state_d  = S_HALT;
        end else if (dec_nop) begin
          pc_d    = pc_q + STEP;
          count_d = count_inc;
          state_d = S_F0;
        end else begin
          exe_d   = 1'b1;
          flags_d = dec_flags;
          args_d  = {rom_data, w1_q, w0_q};
          state_d = S_EXEC;
`ifdef FETCH_TIMEOUT_EN
          wdog_d  = WD_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      S_EXEC: begin
        // jmp_flag and the offset only matter in the cycle ready_flag is seen
        if (ready_flag) begin
          exe_d   = 1'b0;
          flags_d = '0;
          count_d = count_inc;
          pc_d    = jmp_flag ? pc_q + new_exe_addr_offset : pc_q + STEP;
          state_d = S_F0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wdog_q == '0) begin
          exe_d   = 1'b0;
          flags_d = '0;
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
`endif
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      w0_q     <= '0;
      w1_q     <= '0;
      exe_q    <= 1'b0;
      flags_q  <= '0;
      args_q   <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      exe_q    <= exe_d;
      flags_q  <= flags_d;
      args_q   <= args_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      count_q  <= count_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`endif

  assign pc          = pc_q;
  assign exe_flag    = exe_q;
  assign cmd_flags   = flags_q;
  assign cmd_args    = args_q;
  assign halted      = halted_q;
  assign error       = error_q;
  assign instr_count = count_q;

endmodule
